// File: rtl/prbs4_checker_pkg.sv
// rtl/prbs4_checker_pkg.sv - shared types, constants and next-word function for the 4-bit LFSR
//
// Purpose : common definitions for the x^4+x^3+1 pattern checker and generator-side benches.
// Contents: state_t (HUNT/VERIFY/LOCKED), LFSR_W, TAP_MASK, nxt().
package prbs4_checker_pkg;

   localparam int LFSR_W = 4;

   // Feedback taps on bits 3 and 2 (x^4 + x^3 + 1).
   localparam logic [LFSR_W-1:0] TAP_MASK = 4'b1100;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Shift left, feed the XOR of the tapped bits into bit 0.
   function automatic logic [LFSR_W-1:0] nxt(input logic [LFSR_W-1:0] w);
      return {w[LFSR_W-2:0], ^(w & TAP_MASK)};
   endfunction

endpackage

// File: rtl/prbs4_err_counter.sv
// rtl/prbs4_err_counter.sv - saturating error counter with synchronous clear and variable increment
//
// Purpose : counts mismatches; clear is applied before the increment in the same cycle,
//           and any add that would overflow leaves the counter at all-ones.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-low reset
//           i_clr   - synchronous clear
//           i_inc   - add i_amt this cycle
//           i_amt   - increment amount (1..4)
//           o_cnt   - current count (registered)
module prbs4_err_counter #(
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [2:0]       i_amt,
   output logic [ERR_W-1:0] o_cnt
);

   // Wide enough to hold both the count and the increment plus a carry bit.
   localparam int SUM_W = ((ERR_W > 3) ? ERR_W : 3) + 1;

   logic [ERR_W-1:0] r_cnt;
   logic [ERR_W-1:0] w_cnt_nxt;
   logic [SUM_W-1:0] w_base;
   logic [SUM_W-1:0] w_sum;

   always_comb begin
      w_base    = i_clr ? '0 : SUM_W'(r_cnt);
      w_sum     = w_base + SUM_W'(i_amt);
      w_cnt_nxt = w_base[ERR_W-1:0];
      if (i_inc) begin
         if (|w_sum[SUM_W-1:ERR_W]) begin
            w_cnt_nxt = '1;
         end else begin
            w_cnt_nxt = w_sum[ERR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs4_checker.sv
// rtl/prbs4_checker.sv - self-synchronising checker for the 4-bit x^4+x^3+1 LFSR word stream
//
// Purpose : hunts for a non-zero seed, verifies LOCK_CNT consecutive predicted words,
//           then free-runs its prediction and counts mismatches until LOSS_CNT in a row.
// Option  : PRBS4_CHK_BITERR_EN - err_cnt adds the number of differing bits per word.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-low reset
//           in_valid  - in_data carries a new word
//           in_data   - LFSR word, bit 3 = MSB
//           clr_cnt   - synchronous clear of err_cnt and zero_seen
//           locked    - synchronised to the sequence
//           err_pulse - one-cycle pulse per counted mismatch
//           err_cnt   - saturating mismatch count
//           zero_seen - sticky all-zero-word flag
module prbs4_checker
   import prbs4_checker_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic             zero_seen
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [LFSR_W-1:0] r_expected;
   logic [LFSR_W-1:0] w_expected_nxt;
   logic [3:0]        r_good;
   logic [3:0]        w_good_nxt;
   logic [3:0]        r_bad;
   logic [3:0]        w_bad_nxt;
   logic              r_locked;
   logic              r_err_pulse;
   logic              r_zero_seen;
   logic              w_zero_seen_nxt;
   logic              w_zero_word;
   logic              w_match;
   logic              w_count_err;
   logic [2:0]        w_inc_amt;

   assign w_zero_word = in_valid && (in_data == '0);
   assign w_match     = (in_data == r_expected);

`ifdef PRBS4_CHK_BITERR_EN
   logic [LFSR_W-1:0] w_diff;
   assign w_diff    = in_data ^ r_expected;
   assign w_inc_amt = 3'(w_diff[0]) + 3'(w_diff[1]) + 3'(w_diff[2]) + 3'(w_diff[3]);
`else
   assign w_inc_amt = 3'd1;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_expected_nxt = r_expected;
      w_good_nxt     = r_good;
      w_bad_nxt      = r_bad;
      w_count_err    = 1'b0;
      if (in_valid) begin
         case (r_state)
            HUNT: begin
               if (!w_zero_word) begin
                  w_expected_nxt = nxt(in_data);
                  w_good_nxt     = '0;
                  w_state_nxt    = VERIFY;
               end
            end
            VERIFY: begin
               if (w_match) begin
                  w_good_nxt     = r_good + 4'd1;
                  w_expected_nxt = nxt(in_data);
                  if (r_good + 4'd1 == LOCK_N) begin
                     w_state_nxt = LOCKED;
                     w_bad_nxt   = '0;
                  end
               end else if (w_zero_word) begin
                  w_good_nxt  = '0;
                  w_state_nxt = HUNT;
               end else begin
                  // Wrong but plausible word: treat it as a fresh seed.
                  w_expected_nxt = nxt(in_data);
                  w_good_nxt     = '0;
               end
            end
            LOCKED: begin
               // Prediction free-runs so a burst of bad words cannot corrupt it.
               w_expected_nxt = nxt(r_expected);
               if (w_match) begin
                  w_bad_nxt = '0;
               end else begin
                  w_count_err = 1'b1;
                  if (r_bad + 4'd1 == LOSS_N) begin
                     w_bad_nxt   = '0;
                     w_state_nxt = HUNT;
                  end else begin
                     w_bad_nxt = r_bad + 4'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = HUNT;
            end
         endcase
      end
   end

   // A zero word arriving alongside clr_cnt keeps the flag set.
   assign w_zero_seen_nxt = w_zero_word ? 1'b1 : (clr_cnt ? 1'b0 : r_zero_seen);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= HUNT;
         r_expected  <= '0;
         r_good      <= '0;
         r_bad       <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_zero_seen <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_expected  <= w_expected_nxt;
         r_good      <= w_good_nxt;
         r_bad       <= w_bad_nxt;
         r_locked    <= (w_state_nxt == LOCKED);
         r_err_pulse <= w_count_err;
         r_zero_seen <= w_zero_seen_nxt;
      end
   end

   prbs4_err_counter #(
      .ERR_W (ERR_W)
   ) u_err_counter (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clr_cnt),
      .i_inc (w_count_err),
      .i_amt (w_inc_amt),
      .o_cnt (err_cnt)
   );

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign zero_seen = r_zero_seen;

endmodule

// File: tb/tb_prbs4_checker.sv
// tb/tb_prbs4_checker.sv - directed self-checking bench for prbs4_checker (default and ERR_W=2)
module tb_prbs4_checker;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_data;
   logic        clr_cnt;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic        zero_seen;
   logic        locked2;
   logic        err_pulse2;
   logic [1:0]  err_cnt2;
   logic        zero_seen2;

   int          checks;
   int          failures;
   logic [15:0] exp_err;
   logic [1:0]  exp_err2;

   prbs4_checker dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .zero_seen (zero_seen)
   );

   prbs4_checker #(.ERR_W(2)) dut_w2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_cnt   (clr_cnt),
      .locked    (locked2),
      .err_pulse (err_pulse2),
      .err_cnt   (err_cnt2),
      .zero_seen (zero_seen2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int err_amt(input logic [3:0] got, input logic [3:0] expw);
`ifdef PRBS4_CHK_BITERR_EN
      logic [3:0] d;
      d = got ^ expw;
      return int'(d[0]) + int'(d[1]) + int'(d[2]) + int'(d[3]);
`else
      return 1;
`endif
   endfunction

   task automatic bump(input logic [3:0] got, input logic [3:0] expw, input logic clr);
      int e;
      int e2;
      e  = (clr ? 0 : int'(exp_err)) + err_amt(got, expw);
      e2 = (clr ? 0 : int'(exp_err2)) + err_amt(got, expw);
      exp_err  = (e > 65535) ? 16'hFFFF : 16'(e);
      exp_err2 = (e2 > 3) ? 2'd3 : 2'(e2);
   endtask

   task automatic send(input logic [3:0] w, input logic c);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      clr_cnt  = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b1;
      exp_err  = '0;
      exp_err2 = '0;
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'h0;
      clr_cnt  = 1'b0;
      exp_err  = '0;
      exp_err2 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked); end
      checks++;
      if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%b want=0", err_pulse); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
      checks++;
      if (zero_seen !== 1'b0) begin failures++; $display("FAIL reset_zero_seen got=%b want=0", zero_seen); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_lock();
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      send(4'h4, 1'b0);
      send(4'h9, 1'b0);
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b want=0", locked); end
      send(4'h3, 1'b0);
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL lock_after_4_matches got=%b want=1", locked); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL lock_err_cnt got=%0d want=0", err_cnt); end
   endtask

   task automatic test_single_error();
      send(4'h6, 1'b0);
      bump(4'h0, 4'hD, 1'b0);
      send(4'h0, 1'b0);
      checks++;
      if (err_pulse !== 1'b1) begin failures++; $display("FAIL single_err_pulse got=%b want=1", err_pulse); end
      checks++;
      if (err_cnt !== exp_err) begin failures++; $display("FAIL single_err_cnt got=%0d want=%0d", err_cnt, exp_err); end
      checks++;
      if (zero_seen !== 1'b1) begin failures++; $display("FAIL single_zero_seen got=%b want=1", zero_seen); end
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL single_locked got=%b want=1", locked); end
      send(4'hA, 1'b0);
      checks++;
      if (err_pulse !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b want=0", err_pulse); end
      send(4'h5, 1'b0);
      checks++;
      if (err_cnt !== exp_err) begin failures++; $display("FAIL single_no_more_err got=%0d want=%0d", err_cnt, exp_err); end
   endtask

   task automatic test_loss_and_relock();
      bump(4'h0, 4'hB, 1'b0);
      send(4'h0, 1'b0);
      bump(4'h0, 4'h7, 1'b0);
      send(4'h0, 1'b0);
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL loss_early got=%b want=1", locked); end
      bump(4'h0, 4'hF, 1'b0);
      send(4'h0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL loss_locked got=%b want=0", locked); end
      checks++;
      if (err_cnt !== exp_err) begin failures++; $display("FAIL loss_err_cnt got=%0d want=%0d", err_cnt, exp_err); end
      checks++;
      if (err_cnt2 !== 2'd3) begin failures++; $display("FAIL loss_w2_saturate got=%0d want=3", err_cnt2); end
      send(4'hE, 1'b0);
      send(4'hC, 1'b0);
      send(4'h8, 1'b0);
      send(4'h1, 1'b0);
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL relock_early got=%b want=0", locked); end
      send(4'h2, 1'b0);
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL relock_5th got=%b want=1", locked); end
   endtask

   task automatic test_clear_collision();
      bump(4'h7, 4'h4, 1'b0);
      send(4'h7, 1'b0);
      checks++;
      if (err_cnt !== exp_err) begin failures++; $display("FAIL clr_pre_count got=%0d want=%0d", err_cnt, exp_err); end
      send(4'h9, 1'b0);
      bump(4'h5, 4'h3, 1'b1);
      send(4'h5, 1'b1);
      checks++;
      if (err_cnt !== exp_err) begin failures++; $display("FAIL clr_and_err got=%0d want=%0d", err_cnt, exp_err); end
      checks++;
      if (err_cnt2 !== exp_err2) begin failures++; $display("FAIL clr_and_err_w2 got=%0d want=%0d", err_cnt2, exp_err2); end
      checks++;
      if (err_pulse !== 1'b1) begin failures++; $display("FAIL clr_err_pulse got=%b want=1", err_pulse); end
      checks++;
      if (zero_seen !== 1'b0) begin failures++; $display("FAIL clr_zero_seen got=%b want=0", zero_seen); end
      bump(4'h0, 4'h6, 1'b1);
      send(4'h0, 1'b1);
      checks++;
      if (zero_seen !== 1'b1) begin failures++; $display("FAIL clr_with_zero_word got=%b want=1", zero_seen); end
      checks++;
      if (err_cnt !== exp_err) begin failures++; $display("FAIL clr_zero_err got=%0d want=%0d", err_cnt, exp_err); end
      send(4'hD, 1'b0);
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL clr_still_locked got=%b want=1", locked); end
      @(negedge clk);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt  = 1'b0;
      exp_err  = '0;
      exp_err2 = '0;
      checks++;
      if (err_cnt !== exp_err) begin failures++; $display("FAIL clr_idle got=%0d want=0", err_cnt); end
      checks++;
      if (zero_seen !== 1'b0) begin failures++; $display("FAIL clr_idle_zero got=%b want=0", zero_seen); end
   endtask

   task automatic test_stuck_zero();
      pulse_reset();
      for (int i = 0; i < 4; i++) send(4'h0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL stuck_locked got=%b want=0", locked); end
      checks++;
      if (zero_seen !== 1'b1) begin failures++; $display("FAIL stuck_zero_seen got=%b want=1", zero_seen); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL stuck_err_cnt got=%0d want=0", err_cnt); end
   endtask

   task automatic test_verify_reseed();
      pulse_reset();
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      send(4'h4, 1'b0);
      send(4'h7, 1'b0);
      send(4'hF, 1'b0);
      send(4'hE, 1'b0);
      send(4'hC, 1'b0);
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL reseed_early got=%b want=0", locked); end
      send(4'h8, 1'b0);
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL reseed_lock got=%b want=1", locked); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL reseed_err_cnt got=%0d want=0", err_cnt); end
   endtask

`ifdef PRBS4_CHK_BITERR_EN
   task automatic test_biterr();
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      send(4'h4, 1'b0);
      send(4'h9, 1'b0);
      send(4'h3, 1'b0);
      send(4'h9, 1'b0);
      checks++;
      if (err_cnt !== 16'd4) begin failures++; $display("FAIL biterr_count got=%0d want=4", err_cnt); end
      checks++;
      if (err_pulse !== 1'b1) begin failures++; $display("FAIL biterr_pulse got=%b want=1", err_pulse); end
   endtask
`endif

   task automatic test_async_reset();
      pulse_reset();
      send(4'h0, 1'b0);
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      checks++;
      if (zero_seen !== 1'b1) begin failures++; $display("FAIL async_pre_zero got=%b want=1", zero_seen); end
      rst = 1'b0;
      #1;
      checks++;
      if (zero_seen !== 1'b0) begin failures++; $display("FAIL async_zero_seen got=%b want=0", zero_seen); end
      checks++;
      if (locked !== 1'b0 || err_cnt !== 16'd0) begin failures++; $display("FAIL async_outputs got=%b/%0d want=0/0", locked, err_cnt); end
      @(negedge clk);
      rst = 1'b1;
      send(4'h4, 1'b0);
      send(4'h9, 1'b0);
      send(4'h3, 1'b0);
      send(4'h6, 1'b0);
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL async_no_partial got=%b want=0", locked); end
      send(4'hD, 1'b0);
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL async_relock got=%b want=1", locked); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_lock();
      test_single_error();
      test_loss_and_relock();
      test_clear_collision();
      test_stuck_zero();
      test_verify_reseed();
`ifdef PRBS4_CHK_BITERR_EN
      test_biterr();
`endif
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
